l2_arbiter: RTL
===============

// Module: l2_arbiter
// PURPOSE
//  Shares the single L2 cache port between the L1 I-cache and L1 D-cache miss paths.
//  Sits between both L1 controllers and the L2 cache controller and uses the same stb/cyc/resp/retry line handshake.
//  Tie-break is round-robin. The granted request is registered, so L2 sees a stable request until l2_resp.
// PARAMETERS
//  ADDR_W  32   line address width (byte address, line-aligned)
//  LINE_W  256  cache line width in bits
//  PERF_W  32   performance counter width (used only with L2_ARB_PERF_EN)
// PORTS
//  clk          in   1       clock; all state changes on posedge
//  rst          in   1       asynchronous, active-high reset
//  i_stb,i_cyc  in   1       I-cache request (read only)
//  i_addr       in   ADDR_W  I-cache line address
//  i_rdata      out  LINE_W  read line to I-cache
//  i_resp       out  1       one-cycle completion pulse to I-cache
//  i_retry      out  1       I-cache request pending and not yet completed
//  d_stb,d_cyc  in   1       D-cache request
//  d_write      in   1       1 = write-back of a line, 0 = line fill
//  d_addr       in   ADDR_W  D-cache line address
//  d_wdata      in   LINE_W  write-back data
//  d_rdata      out  LINE_W  read line to D-cache
//  d_resp       out  1       one-cycle completion pulse to D-cache
//  d_retry      out  1       D-cache request pending and not yet completed
//  l2_stb,l2_cyc out 1       request to L2
//  l2_write     out  1       registered write flag
//  l2_addr      out  ADDR_W  registered address
//  l2_wdata     out  LINE_W  registered write data
//  l2_rdata     in   LINE_W  L2 read data, valid with l2_resp
//  l2_resp      in   1       L2 completion
//  l2_retry     in   1       ignored: L2 asserts it for every unfinished request
//  perf_*       out  PERF_W  counters: only with L2_ARB_PERF_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state=IDLE, last_grant=I, request regs=0. l2_stb/l2_cyc/l2_write=0, all resp=0.
//  - FSM IDLE -> BUSY -> IDLE.
//  - A requester is active when stb&cyc. Requesters hold their request until resp.
//  - IDLE:
//    - Neither active: stay in IDLE.
//    - One active: grant it.
//    - Both active: grant the one that is not last_grant.
//    - On grant: capture addr, write and wdata (I forces write=0); set grant and last_grant; go to BUSY.
//  - BUSY:
//    - l2_stb=l2_cyc=1. l2_write/l2_addr/l2_wdata come from the registers.
//    - When l2_resp=1: pulse x_resp=1 to the granted requester in that same cycle, then go to IDLE.
//  - Latency: request seen in IDLE at cycle N -> l2_stb at N+1. L2 hit resp at N+1 -> x_resp at N+1.
//    After resp there is one IDLE cycle before the next grant.
//  - x_rdata = l2_rdata combinationally to both requesters; meaningful only with x_resp.
//  - x_retry = x_stb & x_cyc & ~x_resp.
//  - Abort: if the granted requester drops cyc in BUSY, the transaction to L2 still completes.
//    Its resp is suppressed (x_resp=0) and the FSM returns to IDLE.
//  - l2_resp while in IDLE is ignored.
//  - Starvation bound: with both requesters continuously active, grants alternate I/D.
//  - Reset asserted mid-BUSY drops the transaction immediately. The L2 side is reset with the same rst.
// CONFIGURATION
//  - L2_ARB_PERF_EN defined adds three saturating PERF_W counters, cleared by rst:
//    - perf_i_grants: +1 per I grant.
//    - perf_d_grants: +1 per D grant.
//    - perf_conflicts: +1 per IDLE cycle with both requesters active.
//  - Undefined: the perf_* ports and counters do not exist. Datapath timing is identical either way.
// STRUCTURE
//  - Package l2_arb_pkg:
//    - typedef enum {ARB_IDLE, ARB_BUSY} arb_state_t
//    - typedef enum logic {GNT_I, GNT_D} grant_t
//    - constant RESET_LAST_GRANT = GNT_I, so D wins the first tie.
//  - Sub-module l2_arb_perf (counters), instantiated only under L2_ARB_PERF_EN.
//  - Grant, FSM and request registers stay in the top level.
// TESTING
//  1. Lone I request, addr 0x0000_1000, L2 resp 3 cycles later -> l2_addr=0x1000, l2_write=0, single i_resp pulse, d_resp never set.
//  2. I and D active in the same cycle after reset -> D granted first, then I. perf_conflicts=1, each grant count=1.
//  3. Both held active for 8 transactions -> strict D,I,D,I,... alternation; no requester waits more than one transaction.
//  4. D write-back addr 0x0000_2040, wdata=pattern A5..; d_wdata changed after grant -> l2_wdata keeps A5.., l2_write=1 until resp.
//  5. Granted I drops cyc mid-BUSY -> l2_stb held until l2_resp, i_resp stays 0, FSM back in IDLE.
//  6. rst pulsed during BUSY -> l2_stb=0 asynchronously, state IDLE, the next tie goes to D.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter.
//   arb_state_t      : arbiter FSM state
//   grant_t          : which L1 requester owns the L2 port
//   RESET_LAST_GRANT : last_grant after reset (I, so D wins the first tie)
//   pick_grant()     : round-robin choice between the two requesters
package l2_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
   typedef enum logic {GNT_I, GNT_D} grant_t;

   localparam grant_t RESET_LAST_GRANT = GNT_I;

   // On a tie the requester that did not win last time goes next.
   function automatic grant_t pick_grant(input logic i_act, input logic d_act,
                                         input grant_t last);
      if (i_act && d_act) return (last == GNT_I) ? GNT_D : GNT_I;
      return d_act ? GNT_D : GNT_I;
   endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Line-request bus between a cache controller and its next level.
// One instance per link: I-cache, D-cache and L2 port.
//   stb, cyc   request strobe / cycle
//   write      1 = line write-back, 0 = line fill
//   addr       line address
//   wdata      write-back line
//   rdata      returned line, valid with resp
//   resp       one-cycle completion pulse
//   retry      request pending and not yet completed
// master = requester side, slave = responder side.
interface l2_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) ();
   logic              stb;
   logic              cyc;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] rdata;
   logic              resp;
   logic              retry;

   modport master (output stb, cyc, write, addr, wdata,
                   input  rdata, resp, retry);
   modport slave  (input  stb, cyc, write, addr, wdata,
                   output rdata, resp, retry);
endinterface

// File: rtl/l2_arb_perf.sv
// Saturating event counters for the L2 arbiter (L2_ARB_PERF_EN builds only).
//   clk, rst        clock / async active-high reset (clears counters)
//   i_grant_evt     one per I grant
//   d_grant_evt     one per D grant
//   conflict_evt    one per idle cycle with both requesters active
//   perf_*          counter values, stick at all-ones
module l2_arb_perf #(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_grant_evt,
   input  logic              d_grant_evt,
   input  logic              conflict_evt,
   output logic [PERF_W-1:0] perf_i_grants,
   output logic [PERF_W-1:0] perf_d_grants,
   output logic [PERF_W-1:0] perf_conflicts
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_i_grants  <= '0;
         perf_d_grants  <= '0;
         perf_conflicts <= '0;
      end else begin
         if (i_grant_evt && (perf_i_grants != '1))
            perf_i_grants <= perf_i_grants + 1'b1;
         if (d_grant_evt && (perf_d_grants != '1))
            perf_d_grants <= perf_d_grants + 1'b1;
         if (conflict_evt && (perf_conflicts != '1))
            perf_conflicts <= perf_conflicts + 1'b1;
      end
   end
endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single L2 port between I-cache and D-cache miss paths.
// The granted request is registered so L2 sees it stable until l2 resp.
//   clk, rst   clock / async active-high reset
//   i_bus      I-cache requester link (read only; its write/wdata are ignored)
//   d_bus      D-cache requester link
//   l2_bus     link to the L2 controller (its retry is ignored)
//   perf_*     grant/conflict counters, present only when L2_ARB_PERF_EN is defined
//
// state    | meaning
// ARB_IDLE | no request outstanding to L2; grant on any active requester
// ARB_BUSY | registered request driven to L2; wait for l2 resp
module l2_arbiter
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int PERF_W = 32
) (
   input  logic          clk,
   input  logic          rst,
   l2_arbiter_if.slave   i_bus,
   l2_arbiter_if.slave   d_bus,
   l2_arbiter_if.master  l2_bus
`ifdef L2_ARB_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_i_grants,
   output logic [PERF_W-1:0] perf_d_grants,
   output logic [PERF_W-1:0] perf_conflicts
`endif
);
   arb_state_t        state_q;
   grant_t            grant_q;
   grant_t            last_grant_q;
   grant_t            pick;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              i_act;
   logic              d_act;
   logic              busy;
   logic              grant_now;
   logic              unused_sig;

   assign i_act     = i_bus.stb & i_bus.cyc;
   assign d_act     = d_bus.stb & d_bus.cyc;
   assign pick      = pick_grant(i_act, d_act, last_grant_q);
   assign busy      = (state_q == ARB_BUSY);
   assign grant_now = !busy && (i_act || d_act);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= GNT_I;
         last_grant_q <= RESET_LAST_GRANT;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (i_act || d_act) begin
                  state_q      <= ARB_BUSY;
                  grant_q      <= pick;
                  last_grant_q <= pick;
                  if (pick == GNT_D) begin
                     wr_q    <= d_bus.write;
                     addr_q  <= d_bus.addr;
                     wdata_q <= d_bus.wdata;
                  end else begin
                     wr_q    <= 1'b0;
                     addr_q  <= i_bus.addr;
                     wdata_q <= '0;
                  end
               end
            end
            ARB_BUSY: begin
               if (l2_bus.resp) state_q <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign l2_bus.stb   = busy;
   assign l2_bus.cyc   = busy;
   assign l2_bus.write = wr_q;
   assign l2_bus.addr  = addr_q;
   assign l2_bus.wdata = wdata_q;

   // A requester that dropped cyc mid-transaction has aborted: L2 still
   // finishes, but the completion pulse is swallowed.
   assign i_bus.resp  = busy & l2_bus.resp & (grant_q == GNT_I) & i_bus.cyc;
   assign d_bus.resp  = busy & l2_bus.resp & (grant_q == GNT_D) & d_bus.cyc;
   assign i_bus.retry = i_act & ~i_bus.resp;
   assign d_bus.retry = d_act & ~d_bus.resp;
   assign i_bus.rdata = l2_bus.rdata;
   assign d_bus.rdata = l2_bus.rdata;

   assign unused_sig = ^{l2_bus.retry, i_bus.write, i_bus.wdata, (PERF_W != 0)};

`ifdef L2_ARB_PERF_EN
   l2_arb_perf #(.PERF_W(PERF_W)) u_perf (
      .clk            (clk),
      .rst            (rst),
      .i_grant_evt    (grant_now && (pick == GNT_I)),
      .d_grant_evt    (grant_now && (pick == GNT_D)),
      .conflict_evt   (!busy && i_act && d_act),
      .perf_i_grants  (perf_i_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_conflicts (perf_conflicts)
   );
`else
   logic unused_grant;
   assign unused_grant = grant_now;
`endif

endmodule
